// File: rtl/t03_imm_gen_stage.sv
// Registered immediate-generation stage with a 2-deep skid buffer.
// Decodes the RV32/RV64 immediate from the incoming word and registers it with instr/pc.
module t03_imm_gen_stage #(
  parameter int XLEN = 32,
  parameter int PC_W = XLEN
) (
  input  logic            clk,
  input  logic            nRst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic            out_illegal
);

  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_R    = 3'd6;
  localparam logic [2:0] FMT_ILL  = 3'd7;

  if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
    $error("t03_imm_gen_stage: XLEN must be 32 or 64");
  end

  logic [6:0]        w_opcode;
  logic [2:0]        w_fmt;
  logic signed [31:0] w_imm32;
  logic [XLEN-1:0]   w_imm;
  logic              w_accept;
  logic              w_fire;

  logic              r_out_valid;
  logic [31:0]       r_out_instr;
  logic [PC_W-1:0]   r_out_pc;
  logic [XLEN-1:0]   r_out_imm;
  logic [2:0]        r_out_fmt;

  logic              r_skid_valid;
  logic [31:0]       r_skid_instr;
  logic [PC_W-1:0]   r_skid_pc;
  logic [XLEN-1:0]   r_skid_imm;
  logic [2:0]        r_skid_fmt;

  assign w_opcode = in_instr[6:0];

  // Every immediate is built as a signed 32-bit value, so widening to XLEN is a plain sign extension.
  always_comb begin
    w_fmt   = FMT_ILL;
    w_imm32 = '0;
    if (in_instr[1:0] == 2'b11) begin
      case (w_opcode)
        7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
          w_fmt   = FMT_I;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
        end
        7'b0100011: begin
          w_fmt   = FMT_S;
          w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
        end
        7'b1100011: begin
          w_fmt   = FMT_B;
          w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
        end
        7'b1101111: begin
          w_fmt   = FMT_J;
          w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
        end
        7'b0110111, 7'b0010111: begin
          w_fmt   = FMT_U;
          w_imm32 = {in_instr[31:12], 12'b0};
        end
        7'b0110011: w_fmt = FMT_R;
        7'b0001111: w_fmt = FMT_NONE;
        default:    w_fmt = FMT_ILL;
      endcase
    end
  end

  assign w_imm    = XLEN'(w_imm32);
  assign w_accept = in_valid && in_ready;
  assign w_fire   = r_out_valid && out_ready;

  // Output register is refilled from the skid first, so acceptance order is preserved.
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_out_valid  <= 1'b0;
      r_out_instr  <= '0;
      r_out_pc     <= '0;
      r_out_imm    <= '0;
      r_out_fmt    <= FMT_NONE;
      r_skid_valid <= 1'b0;
      r_skid_instr <= '0;
      r_skid_pc    <= '0;
      r_skid_imm   <= '0;
      r_skid_fmt   <= FMT_NONE;
    end else if (flush) begin
      r_out_valid  <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (!r_out_valid || w_fire) begin
      if (r_skid_valid) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= r_skid_instr;
        r_out_pc     <= r_skid_pc;
        r_out_imm    <= r_skid_imm;
        r_out_fmt    <= r_skid_fmt;
        r_skid_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid  <= 1'b1;
        r_out_instr  <= in_instr;
        r_out_pc     <= in_pc;
        r_out_imm    <= w_imm;
        r_out_fmt    <= w_fmt;
      end else begin
        r_out_valid  <= 1'b0;
      end
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
      r_skid_instr <= in_instr;
      r_skid_pc    <= in_pc;
      r_skid_imm   <= w_imm;
      r_skid_fmt   <= w_fmt;
    end
  end

  assign in_ready    = !r_skid_valid;
  assign out_valid   = r_out_valid;
  assign out_instr   = r_out_instr;
  assign out_pc      = r_out_pc;
  assign out_imm     = r_out_imm;
  assign out_fmt     = r_out_fmt;
  assign out_illegal = (r_out_fmt == FMT_ILL);

endmodule

// File: tb/tb_t03_imm_gen_stage.sv
// Scoreboard bench for t03_imm_gen_stage: one XLEN=32 and one XLEN=64 instance,
// directed vectors push expectations, a negedge monitor pops and compares on every fire.
module tb_t03_imm_gen_stage;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] imm;
    logic [2:0]  fmt;
  } item_t;

  logic        clk = 1'b0;
  logic        nRst = 1'b1;
  logic        flush = 1'b0;

  logic        inValid32 = 1'b0, inReady32, outValid32, outReady32 = 1'b0, outIllegal32;
  logic [31:0] inInstr32 = '0, inPc32 = '0, outInstr32, outPc32, outImm32;
  logic [2:0]  outFmt32;

  logic        inValid64 = 1'b0, inReady64, outValid64, outReady64 = 1'b0, outIllegal64;
  logic [31:0] inInstr64 = '0, outInstr64;
  logic [63:0] inPc64 = '0, outPc64, outImm64;
  logic [2:0]  outFmt64;

  item_t q32[$];
  item_t q64[$];
  item_t monItem;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  t03_imm_gen_stage #(.XLEN(32)) dut32 (
    .clk(clk), .nRst(nRst), .flush(flush),
    .in_valid(inValid32), .in_ready(inReady32), .in_instr(inInstr32), .in_pc(inPc32),
    .out_valid(outValid32), .out_ready(outReady32), .out_instr(outInstr32), .out_pc(outPc32),
    .out_imm(outImm32), .out_fmt(outFmt32), .out_illegal(outIllegal32)
  );

  t03_imm_gen_stage #(.XLEN(64)) dut64 (
    .clk(clk), .nRst(nRst), .flush(flush),
    .in_valid(inValid64), .in_ready(inReady64), .in_instr(inInstr64), .in_pc(inPc64),
    .out_valid(outValid64), .out_ready(outReady64), .out_instr(outInstr64), .out_pc(outPc64),
    .out_imm(outImm64), .out_fmt(outFmt64), .out_illegal(outIllegal64)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits (bounded) for in_ready, then records the entry as accepted at the following edge.
  task automatic waitAccept(input bit is64, input logic [63:0] pc, input logic [31:0] instr,
                            input logic [63:0] imm, input logic [2:0] fmt);
    item_t it;
    bit done = 1'b0;
    it.pc = pc; it.instr = instr; it.imm = imm; it.fmt = fmt;
    for (int k = 0; k < 30 && !done; k++) begin
      @(negedge clk);
      if (is64 ? inReady64 : inReady32) begin
        @(posedge clk);
        if (is64) q64.push_back(it); else q32.push_back(it);
        done = 1'b1;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pc 0x%0h never accepted, got 0 wanted 1", pc);
    end
  endtask

  task automatic applyStimulus(input bit is64, input logic [63:0] pc, input logic [31:0] instr,
                               input logic [63:0] imm, input logic [2:0] fmt);
    #1;
    if (is64) begin
      inValid64 = 1'b1; inInstr64 = instr; inPc64 = pc;
    end else begin
      inValid32 = 1'b1; inInstr32 = instr; inPc32 = pc[31:0];
    end
    waitAccept(is64, pc, instr, imm, fmt);
  endtask

  task automatic idle();
    #1;
    inValid32 = 1'b0;
    inValid64 = 1'b0;
  endtask

  // Monitor: every beat that fires must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (nRst && outValid32 && outReady32) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL d32_unexpected: got pc 0x%0h, expected no output", outPc32);
      end else begin
        monItem = q32.pop_front();
        checkOutput("d32_pc", {32'b0, outPc32}, monItem.pc);
        checkOutput("d32_instr", {32'b0, outInstr32}, {32'b0, monItem.instr});
        checkOutput("d32_imm", {32'b0, outImm32}, monItem.imm);
        checkOutput("d32_fmt", 64'(outFmt32), 64'(monItem.fmt));
        checkOutput("d32_illegal", 64'(outIllegal32), 64'(monItem.fmt == 3'd7));
      end
    end
    if (nRst && outValid64 && outReady64) begin
      if (q64.size() == 0) begin
        checks++; errors++;
        $display("[TB] FAIL d64_unexpected: got pc 0x%0h, expected no output", outPc64);
      end else begin
        monItem = q64.pop_front();
        checkOutput("d64_pc", outPc64, monItem.pc);
        checkOutput("d64_instr", {32'b0, outInstr64}, {32'b0, monItem.instr});
        checkOutput("d64_imm", outImm64, monItem.imm);
        checkOutput("d64_fmt", 64'(outFmt64), 64'(monItem.fmt));
        checkOutput("d64_illegal", 64'(outIllegal64), 64'(monItem.fmt == 3'd7));
      end
    end
  end

  initial begin
    #1 nRst = 1'b0;
    #1;
    checkOutput("rst32_valid", 64'(outValid32), 64'd0);
    checkOutput("rst32_ready", 64'(inReady32), 64'd1);
    checkOutput("rst32_fmt", 64'(outFmt32), 64'd0);
    checkOutput("rst32_illegal", 64'(outIllegal32), 64'd0);
    checkOutput("rst32_imm", {32'b0, outImm32}, 64'd0);
    checkOutput("rst64_valid", 64'(outValid64), 64'd0);
    checkOutput("rst64_ready", 64'(inReady64), 64'd1);
    checkOutput("rst64_imm", outImm64, 64'd0);
    #10 nRst = 1'b1;
    @(posedge clk);
    #1 outReady32 = 1'b1; outReady64 = 1'b1;

    // RV64 immediates
    applyStimulus(1, 64'h1000, 32'h800000B7, 64'hFFFFFFFF80000000, 3'd4);
    idle();
    @(negedge clk);
    checkOutput("lat64_valid", 64'(outValid64), 64'd1);
    checkOutput("lat64_imm", outImm64, 64'hFFFFFFFF80000000);
    @(posedge clk);
    applyStimulus(1, 64'h1004, 32'h7FFFF0B7, 64'h000000007FFFF000, 3'd4);
    applyStimulus(1, 64'h1008, 32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    applyStimulus(1, 64'h100C, 32'hFE112C23, 64'hFFFFFFFFFFFFFFF8, 3'd2);
    idle();
    repeat (3) @(posedge clk);

    // RV32 immediates
    applyStimulus(0, 64'h2000, 32'hFFF00093, 64'hFFFFFFFF, 3'd1);
    idle();
    @(negedge clk);
    checkOutput("lat32_valid", 64'(outValid32), 64'd1);
    checkOutput("lat32_fmt", 64'(outFmt32), 64'd1);
    @(posedge clk);
    applyStimulus(0, 64'h2004, 32'hFE000EE3, 64'hFFFFFFFC, 3'd3);
    applyStimulus(0, 64'h2008, 32'h0000006F, 64'h0, 3'd5);
    applyStimulus(0, 64'h200C, 32'h00000000, 64'h0, 3'd7);
    applyStimulus(0, 64'h2010, 32'hFE112C23, 64'hFFFFFFF8, 3'd2);
    applyStimulus(0, 64'h2014, 32'h002081B3, 64'h0, 3'd6);
    applyStimulus(0, 64'h2018, 32'h0000000F, 64'h0, 3'd0);
    applyStimulus(0, 64'h201C, 32'h0000007F, 64'h0, 3'd7);
    applyStimulus(0, 64'h2020, 32'hFFDFF06F, 64'hFFFFFFFC, 3'd5);
    idle();
    repeat (3) @(posedge clk);

    // Back-pressure: fill output and skid, hold a third entry
    #1 outReady32 = 1'b0;
    applyStimulus(0, 64'h100, 32'h00500093, 64'h5, 3'd1);
    applyStimulus(0, 64'h104, 32'h00A00113, 64'hA, 3'd1);
    #1 inValid32 = 1'b1; inInstr32 = 32'h123450B7; inPc32 = 32'h108;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput("bp_in_ready", 64'(inReady32), 64'd0);
      checkOutput("bp_hold_pc", {32'b0, outPc32}, 64'h100);
    end
    @(posedge clk);
    #1 outReady32 = 1'b1;
    waitAccept(0, 64'h108, 32'h123450B7, 64'h12345000, 3'd4);
    idle();
    @(negedge clk);
    checkOutput("bp_third_valid", 64'(outValid32), 64'd1);
    checkOutput("bp_third_pc", {32'b0, outPc32}, 64'h108);
    repeat (3) @(posedge clk);

    // Flush with both entries full and a new entry offered
    #1 outReady32 = 1'b0;
    applyStimulus(0, 64'h200, 32'h00100093, 64'h1, 3'd1);
    applyStimulus(0, 64'h204, 32'h00200093, 64'h2, 3'd1);
    #1 flush = 1'b1; inValid32 = 1'b1; inPc32 = 32'h208; inInstr32 = 32'h00700093;
    @(posedge clk);
    q32.delete();
    #1 flush = 1'b0; inValid32 = 1'b0;
    @(negedge clk);
    checkOutput("flush_valid", 64'(outValid32), 64'd0);
    checkOutput("flush_ready", 64'(inReady32), 64'd1);
    @(posedge clk);
    #1 outReady32 = 1'b1;
    applyStimulus(0, 64'h20C, 32'h00300093, 64'h3, 3'd1);
    idle();
    @(negedge clk);
    checkOutput("post_flush_pc", {32'b0, outPc32}, 64'h20C);
    repeat (3) @(posedge clk);

    // Asynchronous reset mid-stream
    #1 outReady32 = 1'b0;
    applyStimulus(0, 64'h300, 32'h00100093, 64'h1, 3'd1);
    applyStimulus(0, 64'h304, 32'h00200093, 64'h2, 3'd1);
    #3 nRst = 1'b0;
    #1;
    checkOutput("midrst_valid", 64'(outValid32), 64'd0);
    checkOutput("midrst_ready", 64'(inReady32), 64'd1);
    checkOutput("midrst_pc", {32'b0, outPc32}, 64'd0);
    checkOutput("midrst_fmt", 64'(outFmt32), 64'd0);
    q32.delete();
    inValid32 = 1'b0;
    #3 nRst = 1'b1;
    @(posedge clk);
    #1 outReady32 = 1'b1;
    applyStimulus(0, 64'h308, 32'hFFDFF06F, 64'hFFFFFFFC, 3'd5);
    idle();
    @(negedge clk);
    checkOutput("post_rst_valid", 64'(outValid32), 64'd1);
    checkOutput("post_rst_pc", {32'b0, outPc32}, 64'h308);

    repeat (5) @(posedge clk);
    checkOutput("q32_drained", 64'(q32.size()), 64'd0);
    checkOutput("q64_drained", 64'(q64.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
